multdiv_unit: RTL

MULTDIV_UNIT -- requirements
Module: multdiv_unit

---
 rtl/multdiv_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - iterative signed 32-bit multiply/divide unit
// Define MULTDIV_BOOTH4_EN for a radix-4 Booth multiply (16 RUN cycles); divide is unchanged.
module multdiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ctrl_MULT,
  input  logic              ctrl_DIV,
  input  logic [DATA_W-1:0] data_operandA,
  input  logic [DATA_W-1:0] data_operandB,
  output logic [DATA_W-1:0] data_result,
  output logic              data_exception,
  output logic              data_resultRDY
);
  localparam int W = DATA_W;
`ifdef MULTDIV_BOOTH4_EN
  localparam logic [5:0] MUL_LAST = 6'd15;
`else
  localparam logic [5:0] MUL_LAST = 6'd31;
`endif
  localparam logic [5:0] DIV_LAST = 6'd31;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic             start;
  logic             is_mul, neg;
  logic [5:0]       cnt;
  logic [W-1:0]     a_abs, b_abs;
  logic [W-1:0]     bmag, hi, lo, hi_n, lo_n;
  logic [W-1:0]     div_hi, div_lo, mul_hi, mul_lo;
  logic [W:0]       shifted;
  logic             ge;
  logic [2*W-1:0]   prod;
  logic [W-1:0]     res_n;
  logic             exc_n;

  assign start = ctrl_MULT | ctrl_DIV;
  assign a_abs = data_operandA[W-1] ? -data_operandA : data_operandA;
  assign b_abs = data_operandB[W-1] ? -data_operandB : data_operandB;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = IDLE;
      RUN:     if (cnt == 6'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (start) state_nxt = RUN;
  end

  // A start in the DONE cycle aborts that completion, so its strobe is withheld.
  assign data_resultRDY = (state == DONE) && !start;

  // Restoring divide: hi holds the partial remainder, lo shifts dividend out and quotient in.
  always_comb begin
    shifted = {hi, lo[W-1]};
    ge      = shifted >= {1'b0, bmag};
    div_hi  = ge ? (shifted[W-1:0] - bmag) : shifted[W-1:0];
    div_lo  = {lo[W-2:0], ge};
  end

`ifdef MULTDIV_BOOTH4_EN
  logic [2*W-1:0] bacc, bmc, bacc_n, pp;
  logic [W:0]     bmp;

  always_comb begin
    pp = '0;
    case (bmp[2:0])
      3'b001, 3'b010: pp = bmc;
      3'b011:         pp = bmc << 1;
      3'b100:         pp = -(bmc << 1);
      3'b101, 3'b110: pp = -bmc;
      default:        pp = '0;
    endcase
  end

  assign bacc_n = bacc + pp;
  assign prod   = bacc_n;
  assign mul_hi = hi;
  assign mul_lo = lo;
`else
  logic [W-1:0]   amag;
  logic [W:0]     sum;
  logic [2*W-1:0] pmag;

  // Unsigned shift-add on magnitudes; sign is applied once at the end.
  assign sum    = {1'b0, hi} + {1'b0, (lo[0] ? amag : {W{1'b0}})};
  assign mul_hi = sum[W:1];
  assign mul_lo = {sum[0], lo[W-1:1]};
  assign pmag   = {mul_hi, mul_lo};
  assign prod   = neg ? -pmag : pmag;
`endif

  assign hi_n = is_mul ? mul_hi : div_hi;
  assign lo_n = is_mul ? mul_lo : div_lo;

  always_comb begin
    res_n = '0;
    exc_n = 1'b0;
    if (is_mul) begin
      res_n = prod[W-1:0];
      exc_n = !((&prod[2*W-1:W-1]) || !(|prod[2*W-1:W-1]));
    end else if (bmag == '0) begin
      res_n = '0;
      exc_n = 1'b1;
    end else begin
      // Only a positive quotient of 2^31 can overflow (most-negative / -1).
      res_n = neg ? -lo_n : lo_n;
      exc_n = !neg && lo_n[W-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      is_mul         <= 1'b0;
      neg            <= 1'b0;
      cnt            <= '0;
      bmag           <= '0;
      hi             <= '0;
      lo             <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
`ifdef MULTDIV_BOOTH4_EN
      bacc           <= '0;
      bmc            <= '0;
      bmp            <= '0;
`else
      amag           <= '0;
`endif
    end else if (start) begin
      is_mul <= ctrl_MULT;
      neg    <= data_operandA[W-1] ^ data_operandB[W-1];
      cnt    <= ctrl_MULT ? MUL_LAST : DIV_LAST;
      bmag   <= b_abs;
      hi     <= '0;
      lo     <= ctrl_MULT ? b_abs : a_abs;
`ifdef MULTDIV_BOOTH4_EN
      bacc   <= '0;
      bmc    <= {{W{data_operandA[W-1]}}, data_operandA};
      bmp    <= {data_operandB, 1'b0};
`else
      amag   <= a_abs;
`endif
    end else if (state == RUN) begin
      cnt <= cnt - 6'd1;
      hi  <= hi_n;
      lo  <= lo_n;
`ifdef MULTDIV_BOOTH4_EN
      bacc <= bacc_n;
      bmc  <= bmc << 2;
      bmp  <= {{2{bmp[W]}}, bmp[W:2]};
`endif
      if (cnt == 6'd0) begin
        data_result    <= res_n;
        data_exception <= exc_n;
      end
    end
  end
endmodule
